// File: rtl/load_pkg.sv
// Shared FSM state type and RISC-V load funct3 encodings for the load unit.
package load_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension for a little-endian load,
// plus the misalignment and illegal-funct3 checks for the same request.
module load_extract
    import load_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] result,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val   = 8'h00;
        half_val   = addr_lo[1] ? word[31:16] : word[15:0];
        result     = 32'h0000_0000;
        misaligned = 1'b0;
        illegal    = 1'b0;

        case (addr_lo)
            2'd0:    byte_val = word[7:0];
            2'd1:    byte_val = word[15:8];
            2'd2:    byte_val = word[23:16];
            default: byte_val = word[31:24];
        endcase

        case (funct3)
            F3_LB:   result = {{24{byte_val[7]}}, byte_val};
            F3_LBU:  result = {24'h000000, byte_val};
            F3_LH: begin
                result     = {{16{half_val[15]}}, half_val};
                misaligned = addr_lo[0];
            end
            F3_LHU: begin
                result     = {16'h0000, half_val};
                misaligned = addr_lo[0];
            end
            F3_LW: begin
                result     = word;
                misaligned = (addr_lo != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Multi-cycle load unit: one word read over a req/ack handshake, then byte/half
// extraction; rejects bad requests and times out a silent memory.
module load_unit
    import load_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Start,
    input  logic [31:0] i_Addr,
    input  logic [2:0]  i_Funct3,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Err,
    output logic [31:0] o_Data,
    output logic        o_MemReq,
    output logic [31:0] o_MemAddr,
    input  logic        i_MemAck,
    input  logic [31:0] i_MemRData
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       addr_lo_q;
    logic [2:0]       funct3_q;
    logic [2:0]       sel_funct3;
    logic [1:0]       sel_addr_lo;
    logic [31:0]      ext_result;
    logic             ext_misaligned;
    logic             ext_illegal;
    logic             reject;
    logic             timed_out;

    // In IDLE the extractor checks the incoming request; afterwards it works on the latched one.
    assign sel_funct3  = (state == IDLE) ? i_Funct3    : funct3_q;
    assign sel_addr_lo = (state == IDLE) ? i_Addr[1:0] : addr_lo_q;

    load_extract u_extract (
        .funct3     (sel_funct3),
        .addr_lo    (sel_addr_lo),
        .word       (i_MemRData),
        .result     (ext_result),
        .misaligned (ext_misaligned),
        .illegal    (ext_illegal)
    );

    assign reject    = ext_misaligned | ext_illegal;
    assign timed_out = (cnt == CNT_LAST);

    assign o_Busy   = (state != IDLE);
    assign o_Done   = (state == DONE);
    assign o_MemReq = (state == REQ);

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (i_Start) begin
                    next_state = reject ? DONE : REQ;
                end
            end
            REQ: begin
                if (i_MemAck || timed_out) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            cnt       <= '0;
            addr_lo_q <= 2'b00;
            funct3_q  <= 3'b000;
            o_Err     <= 1'b0;
            o_Data    <= 32'h0000_0000;
            o_MemAddr <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (i_Start) begin
                        addr_lo_q <= i_Addr[1:0];
                        funct3_q  <= i_Funct3;
                        cnt       <= '0;
                        if (reject) begin
                            o_Err  <= 1'b1;
                            o_Data <= 32'h0000_0000;
                        end else begin
                            o_MemAddr <= {i_Addr[31:2], 2'b00};
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    // An ack in the final counted cycle still completes the load.
                    if (i_MemAck) begin
                        o_Err  <= 1'b0;
                        o_Data <= ext_result;
                    end else if (timed_out) begin
                        o_Err  <= 1'b1;
                        o_Data <= 32'h0000_0000;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Directed self-checking bench for load_unit, built with a 4-cycle memory
// timeout so both the timeout and the ack-at-deadline cases are reachable.
module tb_load_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    load_unit #(.TIMEOUT_CYCLES(4)) dut (
        .i_Clk      (clk),
        .i_Reset    (reset_n),
        .i_Start    (start),
        .i_Addr     (addr),
        .i_Funct3   (funct3),
        .o_Busy     (busy),
        .o_Done     (done),
        .o_Err      (err),
        .o_Data     (data),
        .o_MemReq   (mem_req),
        .o_MemAddr  (mem_addr),
        .i_MemAck   (mem_ack),
        .i_MemRData (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no end, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd0);
        check({tag, " memreq"}, {31'd0, mem_req}, 32'd0);
    endtask

    // Legal load: ack is raised after wait_cycles silent REQ cycles; ends in the first IDLE cycle.
    task automatic run_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] word, input int wait_cycles,
                            input logic [31:0] exp_maddr, input logic [31:0] exp_data);
        start  = 1'b1;
        addr   = a;
        funct3 = f3;
        step();
        start = 1'b0;
        check({tag, " req c1"}, {31'd0, mem_req}, 32'd1);
        check({tag, " memaddr"}, mem_addr, exp_maddr);
        for (int i = 0; i < wait_cycles; i++) begin
            step();
            check({tag, " req wait"}, {31'd0, mem_req}, 32'd1);
        end
        mem_ack   = 1'b1;
        mem_rdata = word;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " err"}, {31'd0, err}, 32'd0);
        check({tag, " data"}, data, exp_data);
        step();
        check({tag, " idle"}, {31'd0, busy}, 32'd0);
        check({tag, " held"}, data, exp_data);
    endtask

    // Misaligned or illegal request: done+err in cycle 1, no memory request ever.
    task automatic run_reject(input string tag, input logic [31:0] a, input logic [2:0] f3);
        start  = 1'b1;
        addr   = a;
        funct3 = f3;
        step();
        start = 1'b0;
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " err"}, {31'd0, err}, 32'd1);
        check({tag, " data"}, data, 32'd0);
        check({tag, " memreq c1"}, {31'd0, mem_req}, 32'd0);
        step();
        check_idle_outputs({tag, " after"});
    endtask

    task automatic applyStimulus();
        // Reset state
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst err", {31'd0, err}, 32'd0);
        check("rst data", data, 32'd0);
        check("rst memreq", {31'd0, mem_req}, 32'd0);
        check("rst memaddr", mem_addr, 32'd0);
        reset_n = 1'b1;
        step();

        // Ack in the 4th REQ cycle: done 5 cycles after start, also coincides with the deadline
        run_load("lw100", 32'h100, 3'b010, 32'h8899AABB, 3, 32'h100, 32'h8899AABB);
        run_load("lb103", 32'h103, 3'b000, 32'h80112233, 0, 32'h100, 32'hFFFFFF80);
        run_load("lbu103", 32'h103, 3'b100, 32'h80112233, 0, 32'h100, 32'h00000080);
        run_load("lb101", 32'h101, 3'b000, 32'h80112233, 1, 32'h100, 32'h00000022);
        run_load("lbu100", 32'h100, 3'b100, 32'h80112233, 0, 32'h100, 32'h00000033);
        run_load("lh102", 32'h102, 3'b001, 32'h8001FFFF, 0, 32'h100, 32'hFFFF8001);
        run_load("lhu100", 32'h100, 3'b101, 32'h8001FFFF, 0, 32'h100, 32'h0000FFFF);
        run_load("lhu102", 32'h102, 3'b101, 32'h8001FFFF, 2, 32'h100, 32'h00008001);
        run_load("lh200", 32'h200, 3'b001, 32'h12347FFF, 0, 32'h200, 32'h00007FFF);

        run_reject("lw102", 32'h102, 3'b010);
        run_load("lw104", 32'h104, 3'b010, 32'hCAFE0001, 0, 32'h104, 32'hCAFE0001);
        run_reject("lh101", 32'h101, 3'b001);
        run_reject("f3_011", 32'h100, 3'b011);
        run_reject("f3_110", 32'h100, 3'b110);
        run_reject("f3_111", 32'h100, 3'b111);

        // Timeout: four REQ cycles without ack, then error with zeroed data
        run_load("pre_to", 32'h300, 3'b010, 32'h55AA55AA, 0, 32'h300, 32'h55AA55AA);
        start  = 1'b1;
        addr   = 32'h208;
        funct3 = 3'b010;
        step();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("to req", {31'd0, mem_req}, 32'd1);
            check("to nodone", {31'd0, done}, 32'd0);
            step();
        end
        check("to done", {31'd0, done}, 32'd1);
        check("to err", {31'd0, err}, 32'd1);
        check("to data", data, 32'd0);
        check("to memreq", {31'd0, mem_req}, 32'd0);
        step();
        check_idle_outputs("to after");

        // Start during REQ and DONE is ignored
        start  = 1'b1;
        addr   = 32'h400;
        funct3 = 3'b010;
        step();
        addr   = 32'h504;
        funct3 = 3'b011;
        step();
        start = 1'b0;
        check("sreq memaddr", mem_addr, 32'h400);
        check("sreq req", {31'd0, mem_req}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h01020304;
        step();
        mem_ack = 1'b0;
        check("sreq done", {31'd0, done}, 32'd1);
        check("sreq err", {31'd0, err}, 32'd0);
        check("sreq data", data, 32'h01020304);
        start = 1'b1;
        step();
        start = 1'b0;
        check_idle_outputs("sdone");
        step();
        check_idle_outputs("sdone2");

        // Ack in IDLE is ignored
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        step();
        mem_ack = 1'b0;
        check_idle_outputs("ack idle");
        check("ack idle data", data, 32'h01020304);

        // Asynchronous reset mid-REQ, then a late ack
        start  = 1'b1;
        addr   = 32'h600;
        funct3 = 3'b010;
        step();
        start = 1'b0;
        check("mid req", {31'd0, mem_req}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("mid busy", {31'd0, busy}, 32'd0);
        check("mid memreq", {31'd0, mem_req}, 32'd0);
        check("mid data", data, 32'd0);
        check("mid memaddr", mem_addr, 32'd0);
        check("mid err", {31'd0, err}, 32'd0);
        step();
        reset_n   = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h77777777;
        step();
        mem_ack = 1'b0;
        check_idle_outputs("late ack");
        check("late ack data", data, 32'd0);

        run_load("post_rst", 32'h701, 3'b100, 32'h0000A500, 0, 32'h700, 32'h000000A5);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        addr      = 32'd0;
        funct3    = 3'b000;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        step();
        step();
        applyStimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
